multicycle_sequencer: RTL

Multi-cycle sequencer for the CPU datapath. Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and gates the PC, instruction register, register file and data memory enables. Adds wait-state handshakes on instruction and data memory. Sits between the instruction decoder (whose outputs it consumes) and the top-level datapath registers.

---
 rtl/multicycle_sequencer_pkg.sv | 50 +++++
 rtl/multicycle_sequencer_if.sv | 57 +++++
 rtl/multicycle_sequencer_mem_wait_timer.sv | 46 ++++
 rtl/multicycle_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, PC source
// codes, decoder control bundle and the effective-PC-source helper.
// Optional feature macro used by this slice: SEQ_PERF_CNT_EN.
package multicycle_sequencer_pkg;

    // State encoding kept as plain constants so legacy decoders can match on it
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_FAULT  = 3'd7;

    // PC source codes shared with the instruction decoder
    localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_REG    = 2'd2;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd3;

    // Wait timer width covers MEM_TIMEOUT up to 255
    localparam int unsigned TIMER_W = 8;

    // Stall counter width for the optional performance counter
    localparam int unsigned STALL_W = 32;

    // Decoder control outputs consumed by the sequencer
    typedef struct packed {
        logic mem_write;
        logic mem_to_reg;
        logic reg_write_en;
        logic link;
    } dec_ctrl_t;

    // A branch that is not taken falls back to the sequential PC
    function automatic logic [1:0] eff_pc_sel(input logic [1:0] choose,
                                              input logic       taken);
        logic [1:0] sel;
        case (choose)
            PC_SEL_SEQ:    sel = PC_SEL_SEQ;
            PC_SEL_BRANCH: sel = taken ? PC_SEL_BRANCH : PC_SEL_SEQ;
            PC_SEL_REG:    sel = PC_SEL_REG;
            PC_SEL_JUMP:   sel = PC_SEL_JUMP;
            default:       sel = PC_SEL_SEQ;
        endcase
        return sel;
    endfunction

endpackage : multicycle_sequencer_pkg

// File: rtl/multicycle_sequencer_if.sv
// Bundle between the multi-cycle sequencer, the instruction decoder, the
// memories and the datapath registers. The master side is the sequencer.
// Optional feature macro: SEQ_PERF_CNT_EN adds stall_cycles.
interface multicycle_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    import multicycle_sequencer_pkg::*;

    // Control and handshake inputs to the sequencer
    logic             start;
    logic             halt_req;
    logic             imem_ready;
    logic             dmem_ready;
    logic [1:0]       pc_choose;
    logic             branch_taken;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write_en;
    logic             link;

    // Strobes and status produced by the sequencer
    logic             imem_req;
    logic             ir_load;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             busy;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
`ifdef SEQ_PERF_CNT_EN
    logic [STALL_W-1:0] stall_cycles;
`endif

    modport master (
        input  start, halt_req, imem_ready, dmem_ready, pc_choose,
               branch_taken, mem_write, mem_to_reg, reg_write_en, link,
        output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
               busy, fault, state, retired
`ifdef SEQ_PERF_CNT_EN
        , output stall_cycles
`endif
    );

    modport slave (
        output start, halt_req, imem_ready, dmem_ready, pc_choose,
               branch_taken, mem_write, mem_to_reg, reg_write_en, link,
        input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
               busy, fault, state, retired
`ifdef SEQ_PERF_CNT_EN
        , input stall_cycles
`endif
    );

endinterface : multicycle_sequencer_if

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Wait-state timer for memory handshakes: counts cycles spent waiting for a
// ready, clears on every sequencer state change, and flags when the wait has
// reached its limit so the waiting cycle can fault unless ready arrives.
module multicycle_sequencer_mem_wait_timer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    // Number of already-waited cycles at which the current waiting cycle is the last
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q, count_d;
    logic               at_limit_q, at_limit_d;

    // Next count: clear wins, otherwise count waiting cycles and saturate
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + TIMER_W'(1);
        end
        at_limit_d = (count_d == LIMIT);
    end

    // Counter and registered expiry flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            at_limit_q <= (LIMIT == '0);
        end else begin
            count_q    <= count_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign expire_o = at_limit_q;

endmodule : multicycle_sequencer_mem_wait_timer

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB, gates
// the PC, IR, register-file and data-memory enables, handles memory wait
// states with a timeout into FAULT, and counts retired instructions.
// Optional feature macro: SEQ_PERF_CNT_EN adds a saturating stall counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_sequencer_if.master bus
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Per-cycle strobes decoded from the current state and handshakes
    logic imem_req_c;
    logic ir_load_c;
    logic dmem_req_c;
    logic dmem_we_c;
    logic rf_we_c;
    logic retire_c;
    logic wait_c;
    logic tmr_clr_c;
    logic tmr_expire;

    dec_ctrl_t dec;

    assign dec = {bus.mem_write, bus.mem_to_reg, bus.reg_write_en, bus.link};

    // State and retired-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and strobe decode; retire is folded in after the case
    always_comb begin
        state_d    = state_q;
        retired_d  = retired_q;
        imem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        retire_c   = 1'b0;
        wait_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_load_c = 1'b1;
                    state_d   = ST_DECODE;
                end else begin
                    wait_c = 1'b1;
                    if (tmr_expire) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.mem_write || dec.mem_to_reg) begin
                    state_d = ST_MEM;
                end else if (dec.reg_write_en || dec.link) begin
                    state_d = ST_WB;
                end else begin
                    retire_c = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = dec.mem_write;
                if (bus.dmem_ready) begin
                    if (dec.mem_to_reg) begin
                        state_d = ST_WB;
                    end else begin
                        retire_c = 1'b1;
                    end
                end else begin
                    wait_c = 1'b1;
                    if (tmr_expire) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_WB: begin
                rf_we_c  = 1'b1;
                retire_c = 1'b1;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (retire_c) begin
            state_d   = bus.halt_req ? ST_HALT : ST_FETCH;
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Timer restarts whenever the state changes, so it times each FETCH/MEM visit
    assign tmr_clr_c = (state_d != state_q);

    multicycle_sequencer_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr_c),
        .en_i     (wait_c),
        .expire_o (tmr_expire)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    // Saturating count of memory wait cycles
    always_comb begin
        stall_d = stall_q;
        if (wait_c && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

    // Strobes follow the state register, so reset drops them without a clock
    assign bus.imem_req = imem_req_c;
    assign bus.ir_load  = ir_load_c;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_we  = dmem_we_c;
    assign bus.rf_we    = rf_we_c;
    assign bus.pc_we    = retire_c;
    assign bus.pc_sel   = retire_c ? eff_pc_sel(bus.pc_choose, bus.branch_taken)
                                   : PC_SEL_SEQ;
    assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_HALT) &&
                          (state_q != ST_FAULT);
    assign bus.fault    = (state_q == ST_FAULT);
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;

endmodule : multicycle_sequencer
